// File: rtl/saber_pkg.sv
// Shared constants and types for the Saber polynomial-multiplier result path.
package saber_pkg;

   localparam int SABER_N      = 256;
   localparam int SABER_EQ     = 13;
   localparam int SABER_EP     = 10;
   localparam int SABER_H1     = 1 << (SABER_EQ - SABER_EP - 1);
   localparam int SABER_LANE_W = 16;
   localparam int BRAM_ADDR_W  = 7;
   localparam int PACK_WORD_W  = 64;
   localparam int PACK_BUF_W   = 2 * PACK_WORD_W;
   localparam int PACK_CNT_W   = $clog2(PACK_BUF_W);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } packer_state_e;

endpackage

// File: rtl/polmul_result_packer_lane_round.sv
// One coefficient lane: keep COEFF_W bits, add the rounding constant, shift down.
module polmul_lane_round #(
   parameter int LANE_W      = 16,
   parameter int COEFF_W     = 13,
   parameter int ROUND_SHIFT = 0,
   parameter int ROUND_CONST = 0,
   parameter int OUT_W       = COEFF_W - ROUND_SHIFT
) (
   input  logic [LANE_W-1:0] lane_in,
   output logic [OUT_W-1:0]  coeff_out
);

   logic [COEFF_W-1:0] c_sum;
   logic               unused_hi;

   // The add wraps naturally at COEFF_W bits, giving the mod 2^COEFF_W result.
   always_comb begin
      c_sum     = lane_in[COEFF_W-1:0] + COEFF_W'(ROUND_CONST);
      coeff_out = OUT_W'(c_sum >> ROUND_SHIFT);
   end

   assign unused_hi = ^lane_in[LANE_W-1:COEFF_W];

endmodule

// File: rtl/polmul_result_packer.sv
// Unloads 256 coefficients from the multiplier 4 at a time, rounds them and packs a dense 64-bit stream.
//
// state    | meaning
// ST_IDLE  | waiting for start
// ST_ISSUE | one mul_read per cycle for N_GROUPS cycles
// ST_DRAIN | waiting for in-flight reads to land and the pack buffer to empty
// ST_DONE  | one-cycle done pulse, start ignored
module polmul_result_packer
   import saber_pkg::*;
#(
   parameter int LANE_W      = SABER_LANE_W,
   parameter int COEFF_W     = SABER_EQ,
   parameter int ROUND_SHIFT = 0,
   parameter int ROUND_CONST = 0,
   parameter int READ_LAT    = 1,
   parameter int N_GROUPS    = SABER_N / 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [BRAM_ADDR_W-1:0] base_addr,
   output logic                   mul_read,
   input  logic [4*LANE_W-1:0]    coeff4x_in,
   output logic                   wr_en,
   output logic [BRAM_ADDR_W-1:0] wr_addr,
   output logic [PACK_WORD_W-1:0] wr_data,
   output logic                   busy,
   output logic                   done
);

   localparam int OUT_W     = COEFF_W - ROUND_SHIFT;
   localparam int GRP_W     = 4 * OUT_W;
   localparam int GRP_CNT_W = $clog2(N_GROUPS);

   packer_state_e              state_q, state_d;
   logic [GRP_CNT_W-1:0]       grp_cnt_q, grp_cnt_d;
   logic [READ_LAT-1:0]        vpipe_q, vpipe_d;
   logic [BRAM_ADDR_W-1:0]     base_q, base_d;
   logic [PACK_BUF_W-1:0]      pack_q, pack_d;
   logic [PACK_CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
   logic [BRAM_ADDR_W-1:0]     word_idx_q, word_idx_d;
   logic                       wr_en_q, wr_en_d;
   logic [BRAM_ADDR_W-1:0]     wr_addr_q, wr_addr_d;
   logic [PACK_WORD_W-1:0]     wr_data_q, wr_data_d;

   logic                       start_acc;
   logic                       cap_vld;
   logic                       emit;
   logic [OUT_W-1:0]           lane_out [4];
   logic [GRP_W-1:0]           grp_bits;
   logic [PACK_BUF_W-1:0]      pack_app;
   logic [PACK_CNT_W:0]        cnt_app;

   for (genvar k = 0; k < 4; k++) begin : g_lane
      polmul_lane_round #(
         .LANE_W      (LANE_W),
         .COEFF_W     (COEFF_W),
         .ROUND_SHIFT (ROUND_SHIFT),
         .ROUND_CONST (ROUND_CONST),
         .OUT_W       (OUT_W)
      ) u_lane (
         .lane_in   (coeff4x_in[k*LANE_W +: LANE_W]),
         .coeff_out (lane_out[k])
      );
   end

   assign grp_bits = {lane_out[3], lane_out[2], lane_out[1], lane_out[0]};
   assign cap_vld  = vpipe_q[READ_LAT-1];

   always_comb begin
      state_d   = state_q;
      grp_cnt_d = grp_cnt_q;
      base_d    = base_q;
      mul_read  = 1'b0;
      busy      = 1'b1;
      done      = 1'b0;
      start_acc = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            busy = 1'b0;
            if (start) begin
               start_acc = 1'b1;
               state_d   = ST_ISSUE;
               grp_cnt_d = '0;
               base_d    = base_addr;
            end
         end
         ST_ISSUE: begin
            mul_read = 1'b1;
            if (grp_cnt_q == GRP_CNT_W'(N_GROUPS - 1)) begin
               state_d = ST_DRAIN;
            end else begin
               grp_cnt_d = grp_cnt_q + 1'b1;
            end
         end
         ST_DRAIN: begin
            if (vpipe_q == '0 && bit_cnt_q == '0) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            done    = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Append a captured group at bit_cnt; at most one full word can appear per group.
   always_comb begin
      pack_app = pack_q;
      cnt_app  = {1'b0, bit_cnt_q};
      if (cap_vld) begin
         pack_app = pack_q | ({{(PACK_BUF_W-GRP_W){1'b0}}, grp_bits} << bit_cnt_q);
         cnt_app  = cnt_app + (PACK_CNT_W+1)'(GRP_W);
      end
      emit       = (cnt_app >= (PACK_CNT_W+1)'(PACK_WORD_W));
      pack_d     = emit ? (pack_app >> PACK_WORD_W) : pack_app;
      bit_cnt_d  = emit ? PACK_CNT_W'(cnt_app - (PACK_CNT_W+1)'(PACK_WORD_W)) : cnt_app[PACK_CNT_W-1:0];
      word_idx_d = emit ? word_idx_q + 1'b1 : word_idx_q;
      wr_en_d    = emit;
      wr_addr_d  = emit ? base_q + word_idx_q : wr_addr_q;
      wr_data_d  = emit ? pack_app[PACK_WORD_W-1:0] : wr_data_q;
      vpipe_d    = (vpipe_q << 1) | READ_LAT'(mul_read);
      if (start_acc) begin
         pack_d     = '0;
         bit_cnt_d  = '0;
         word_idx_d = '0;
         vpipe_d    = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         grp_cnt_q  <= '0;
         vpipe_q    <= '0;
         base_q     <= '0;
         pack_q     <= '0;
         bit_cnt_q  <= '0;
         word_idx_q <= '0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         grp_cnt_q  <= grp_cnt_d;
         vpipe_q    <= vpipe_d;
         base_q     <= base_d;
         pack_q     <= pack_d;
         bit_cnt_q  <= bit_cnt_d;
         word_idx_q <= word_idx_d;
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
      end
   end

   assign wr_en   = wr_en_q;
   assign wr_addr = wr_addr_q;
   assign wr_data = wr_data_q;

endmodule

// File: tb/tb_polmul_result_packer.sv
// Bench for polmul_result_packer: default instance plus a rounding instance, checked against a bitstream model.
module tb_polmul_result_packer;

   logic        clk = 1'b0;
   logic        rst;
   logic        start0, start1;
   logic [6:0]  base0, base1;
   logic        mul_read0, mul_read1;
   logic [63:0] coeff0, coeff1;
   logic        wr_en0, wr_en1;
   logic [6:0]  wr_addr0, wr_addr1;
   logic [63:0] wr_data0, wr_data1;
   logic        busy0, busy1;
   logic        done0, done1;

   int          cyc = 0;
   int          vectors = 0;
   int          miscompares = 0;

   logic [15:0] coef_mem [2][256];
   int          rd_cnt [2];
   bit          rd_prev [2];
   int          mon_wr [2], mon_rd [2], mon_busy [2], mon_done [2];
   int          first_rd [2], last_wr [2], done_cyc [2];
   logic [63:0] mon_data [2][64];
   logic [6:0]  mon_addr [2][64];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   polmul_result_packer u_dut0 (
      .clk(clk), .rst(rst), .start(start0), .base_addr(base0), .mul_read(mul_read0),
      .coeff4x_in(coeff0), .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0),
      .busy(busy0), .done(done0)
   );

   polmul_result_packer #(.ROUND_SHIFT(3), .ROUND_CONST(4)) u_dut1 (
      .clk(clk), .rst(rst), .start(start1), .base_addr(base1), .mul_read(mul_read1),
      .coeff4x_in(coeff1), .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1),
      .busy(busy1), .done(done1)
   );

   function automatic logic [63:0] grp_word(input int d, input int g);
      logic [63:0] w;
      for (int k = 0; k < 4; k++) w[16*k +: 16] = coef_mem[d][4*g + k];
      return w;
   endfunction

   // Expected word w: bit p of the stream is bit (p mod OUT_W) of rounded coefficient p / OUT_W.
   function automatic logic [63:0] model_word(input int d, input int w);
      int          rs, rc, ow, p, v;
      logic [63:0] r;
      rs = (d == 1) ? 3 : 0;
      rc = (d == 1) ? 4 : 0;
      ow = 13 - rs;
      r  = '0;
      for (int b = 0; b < 64; b++) begin
         p    = 64 * w + b;
         v    = (((int'(coef_mem[d][p / ow]) & 8191) + rc) % 8192) >> rs;
         r[b] = ((v >> (p % ow)) & 1) != 0;
      end
      return r;
   endfunction

   task automatic sample(input int d, input logic mr, input logic we, input logic [6:0] wa,
                         input logic [63:0] wd, input logic bz, input logic dn);
      if (we) begin
         if (mon_wr[d] < 64) begin
            mon_data[d][mon_wr[d]] = wd;
            mon_addr[d][mon_wr[d]] = wa;
         end
         mon_wr[d]++;
         last_wr[d] = cyc;
      end
      if (mr) begin
         if (mon_rd[d] == 0) first_rd[d] = cyc;
         mon_rd[d]++;
      end
      if (bz) mon_busy[d]++;
      if (dn) begin
         mon_done[d]++;
         done_cyc[d] = cyc;
      end
   endtask

   // Multiplier model: data for a read in cycle t is presented from mid-cycle t+1.
   always @(negedge clk) begin
      if (rd_prev[0]) begin
         coeff0 = grp_word(0, rd_cnt[0] % 64);
         rd_cnt[0]++;
      end
      if (rd_prev[1]) begin
         coeff1 = grp_word(1, rd_cnt[1] % 64);
         rd_cnt[1]++;
      end
      rd_prev[0] = mul_read0;
      rd_prev[1] = mul_read1;
      sample(0, mul_read0, wr_en0, wr_addr0, wr_data0, busy0, done0);
      sample(1, mul_read1, wr_en1, wr_addr1, wr_data1, busy1, done1);
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic clear_mon(input int d);
      mon_wr[d] = 0; mon_rd[d] = 0; mon_busy[d] = 0; mon_done[d] = 0;
      first_rd[d] = -1; last_wr[d] = -1; done_cyc[d] = -1;
      rd_cnt[d] = 0; rd_prev[d] = 1'b0;
   endtask

   task automatic set_start(input int d, input logic v);
      if (d == 0) start0 = v; else start1 = v;
   endtask

   task automatic run_job(input int d, input logic [6:0] base, output int s_cyc);
      clear_mon(d);
      if (d == 0) base0 = base; else base1 = base;
      set_start(d, 1'b1);
      s_cyc = cyc;
      @(negedge clk); #1;
      set_start(d, 1'b0);
      for (int i = 0; i < 300 && mon_done[d] == 0; i++) begin
         @(negedge clk); #1;
      end
      repeat (6) @(negedge clk);
      #1;
   endtask

   task automatic check_job(input int d, input logic [6:0] base, input int nwords,
                            input int s_cyc, input string tag);
      logic [6:0] ea;
      check($sformatf("%s.writes", tag), mon_wr[d], nwords);
      check($sformatf("%s.reads", tag), mon_rd[d], 64);
      check($sformatf("%s.done_cnt", tag), mon_done[d], 1);
      check($sformatf("%s.busy_cyc", tag), mon_busy[d], 67);
      check($sformatf("%s.first_rd_lat", tag), first_rd[d] - s_cyc, 1);
      check($sformatf("%s.last_wr_lat", tag), last_wr[d] - s_cyc, 66);
      check($sformatf("%s.done_lat", tag), done_cyc[d] - s_cyc, 67);
      for (int w = 0; w < nwords && w < mon_wr[d] && w < 64; w++) begin
         ea = base + 7'(w);
         check($sformatf("%s.addr[%0d]", tag, w), mon_addr[d][w], ea);
         check($sformatf("%s.data[%0d]", tag, w), mon_data[d][w], model_word(d, w));
      end
   endtask

   task automatic fill_random(input int d);
      for (int i = 0; i < 256; i++) coef_mem[d][i] = 16'($urandom);
   endtask

   initial begin
      int s;
      int wr_before;
      rst = 1'b1; start0 = 1'b0; start1 = 1'b0; base0 = '0; base1 = '0;
      coeff0 = '0; coeff1 = '0;
      clear_mon(0); clear_mon(1);
      repeat (3) @(negedge clk);
      #1;
      check("rst.mul_read0", mul_read0, 0);
      check("rst.wr_en0", wr_en0, 0);
      check("rst.wr_addr0", wr_addr0, 0);
      check("rst.wr_data0", wr_data0, 0);
      check("rst.busy0", busy0, 0);
      check("rst.done0", done0, 0);
      check("rst.mul_read1", mul_read1, 0);
      check("rst.wr_en1", wr_en1, 0);
      check("rst.busy1", busy1, 0);
      check("rst.done1", done1, 0);
      rst = 1'b0;
      @(negedge clk); #1;

      for (int i = 0; i < 256; i++) coef_mem[0][i] = 16'(i);
      run_job(0, 7'd0, s);
      check_job(0, 7'd0, 52, s, "ramp");
      check("ramp.word0_const", mon_data[0][0], 64'h0040_0180_0800_2000);

      for (int i = 0; i < 256; i++) coef_mem[0][i] = 16'hFFFF;
      run_job(0, 7'd0, s);
      check_job(0, 7'd0, 52, s, "ones");
      check("ones.word0_const", mon_data[0][0], 64'hFFFF_FFFF_FFFF_FFFF);
      check("ones.word51_const", mon_data[0][51], 64'hFFFF_FFFF_FFFF_FFFF);

      for (int i = 0; i < 256; i++) begin
         case (i % 4)
            0:       coef_mem[1][i] = {3'($urandom), 13'h1FFC};
            1:       coef_mem[1][i] = 16'h0004;
            default: coef_mem[1][i] = 16'($urandom);
         endcase
      end
      run_job(1, 7'd9, s);
      check_job(1, 7'd9, 40, s, "round");
      check("round.word0_lo20", {44'd0, mon_data[1][0][19:0]}, 64'h0_0400);

      fill_random(0);
      run_job(0, 7'd100, s);
      check_job(0, 7'd100, 52, s, "wrap");
      check("wrap.addr27", mon_addr[0][27], 127);
      check("wrap.addr28", mon_addr[0][28], 0);

      fill_random(0);
      clear_mon(0);
      base0 = 7'd5;
      start0 = 1'b1;
      @(negedge clk); #1;
      start0 = 1'b0;
      for (int i = 0; i < 200 && mon_rd[0] < 30; i++) begin
         @(negedge clk); #1;
      end
      check("abort.reads_seen", mon_rd[0], 30);
      rst = 1'b1;
      @(posedge clk); #1;
      check("abort.mul_read", mul_read0, 0);
      check("abort.wr_en", wr_en0, 0);
      check("abort.busy", busy0, 0);
      wr_before = mon_wr[0];
      @(negedge clk); #1;
      rst = 1'b0;
      repeat (10) @(negedge clk);
      #1;
      check("abort.no_writes", mon_wr[0], wr_before);
      check("abort.no_done", mon_done[0], 0);
      fill_random(0);
      run_job(0, 7'd3, s);
      check_job(0, 7'd3, 52, s, "after_abort");

      fill_random(0);
      clear_mon(0);
      base0 = 7'd0;
      start0 = 1'b1;
      s = cyc;
      @(negedge clk); #1;
      start0 = 1'b0;
      repeat (9) @(negedge clk);
      #1;
      start0 = 1'b1;
      @(negedge clk); #1;
      start0 = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk); #1;
         if (done0) break;
      end
      start0 = 1'b1;
      @(negedge clk); #1;
      start0 = 1'b0;
      repeat (10) @(negedge clk);
      #1;
      check_job(0, 7'd0, 52, s, "restart");
      check("restart.busy_after", busy0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
